// File: rtl/encoder_step_counter_if.sv
`default_nettype none
// ============================================================================
// Module : encoder_step_counter_if
// Purpose: Bundles the decoder-side step/polarity pulses, the position
//          clear/load controls and the position/speed/stall results of the
//          encoder step counter.
// Ports  : master - drives step, polarity, clear, load, load value;
//                   observes position, direction, period, status flags
//          slave  - the counter itself (mirror image of master)
// Rev    : 1.0  initial release
// ============================================================================
interface encoder_step_counter_if #(
  parameter int POS_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 20
);
  logic                    i_step;
  logic                    i_polarity;
  logic                    i_clear;
  logic                    i_load;
  logic [POS_WIDTH-1:0]    i_load_value;
  logic [POS_WIDTH-1:0]    o_position;
  logic                    o_direction;
  logic [PERIOD_WIDTH-1:0] o_period;
  logic                    o_period_valid;
  logic                    o_new_period;
  logic                    o_stalled;

  modport master (
    output i_step, i_polarity, i_clear, i_load, i_load_value,
    input  o_position, o_direction, o_period, o_period_valid,
           o_new_period, o_stalled
  );

  modport slave (
    input  i_step, i_polarity, i_clear, i_load, i_load_value,
    output o_position, o_direction, o_period, o_period_valid,
           o_new_period, o_stalled
  );
endinterface
`default_nettype wire

// File: rtl/encoder_step_counter.sv
`default_nettype none
// ============================================================================
// Module : encoder_step_counter
// Purpose: Tracks signed motor position from decoder step pulses, measures
//          the cycle interval between consecutive same-direction steps and
//          flags a stall when steps stop arriving.
// Ports  : i_clk   - master clock
//          i_rst_n - asynchronous active-low reset
//          bus     - slave modport: step/polarity/clear/load inputs,
//                    position/direction/period/valid/new_period/stalled
//                    outputs (all outputs registered)
// Rev    : 1.0  initial release
// ============================================================================
module encoder_step_counter #(
  parameter int POS_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 20,
  parameter int STALL_CYCLES = 1000000
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  encoder_step_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RUNNING = 2'd2
  } state_e;

  localparam logic [PERIOD_WIDTH-1:0] C_STALL    = PERIOD_WIDTH'(STALL_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] C_STALL_M1 = PERIOD_WIDTH'(STALL_CYCLES - 1);
  localparam logic [PERIOD_WIDTH-1:0] C_CNT_ONE  = PERIOD_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0]    C_POS_ONE  = POS_WIDTH'(1);

  state_e                  state_q,        state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q,          cnt_d;
  logic [POS_WIDTH-1:0]    position_q,     position_d;
  logic                    direction_q,    direction_d;
  logic [PERIOD_WIDTH-1:0] period_q,       period_d;
  logic                    period_valid_q, period_valid_d;
  logic                    new_period_q,   new_period_d;
  logic                    stalled_q,      stalled_d;

  // Interval of a step this cycle is cnt_q+1; it is usable as a period only
  // when strictly below the stall threshold. Comparing cnt_q against
  // STALL_CYCLES-1 avoids forming cnt_q+1, which could overflow when
  // STALL_CYCLES sits at the top of the counter range.
  logic w_in_window;
  assign w_in_window = (cnt_q < C_STALL_M1);

  // Position path: clear beats load beats step; modular wrap.
  always_comb begin
    position_d = position_q;
    if (bus.i_clear) begin
      position_d = '0;
    end else if (bus.i_load) begin
      position_d = bus.i_load_value;
    end else if (bus.i_step) begin
      position_d = bus.i_polarity ? (position_q + C_POS_ONE)
                                  : (position_q - C_POS_ONE);
    end
  end

  // Interval counter saturates so it cannot wrap while idle.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_step) begin
      cnt_d = '0;
    end else if (cnt_q < C_STALL) begin
      cnt_d = cnt_q + C_CNT_ONE;
    end
  end

  // Speed / stall state machine.
  always_comb begin
    state_d        = state_q;
    direction_d    = direction_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    new_period_d   = 1'b0;
    stalled_d      = stalled_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_step) begin
          state_d        = S_ARMED;
          direction_d    = bus.i_polarity;
          stalled_d      = 1'b0;
          period_d       = '0;
          period_valid_d = 1'b0;
        end
      end

      S_ARMED, S_RUNNING: begin
        if (bus.i_step) begin
          if (!w_in_window || (bus.i_polarity != direction_q)) begin
            // A too-late step and a reversal both just re-establish a
            // reference step; neither yields a period.
            state_d        = S_ARMED;
            direction_d    = bus.i_polarity;
            period_d       = '0;
            period_valid_d = 1'b0;
          end else begin
            state_d        = S_RUNNING;
            period_d       = cnt_q + C_CNT_ONE;
            period_valid_d = 1'b1;
            new_period_d   = 1'b1;
          end
        end else if (cnt_q >= C_STALL_M1) begin
          // This cycle's interval reaches STALL_CYCLES without a step.
          state_d        = S_IDLE;
          stalled_d      = 1'b1;
          period_d       = '0;
          period_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      position_q     <= '0;
      direction_q    <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      new_period_q   <= 1'b0;
      stalled_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      position_q     <= position_d;
      direction_q    <= direction_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      new_period_q   <= new_period_d;
      stalled_q      <= stalled_d;
    end
  end

  assign bus.o_position     = position_q;
  assign bus.o_direction    = direction_q;
  assign bus.o_period       = period_q;
  assign bus.o_period_valid = period_valid_q;
  assign bus.o_new_period   = new_period_q;
  assign bus.o_stalled      = stalled_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_step_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_encoder_step_counter
// Purpose: Self-checking bench for encoder_step_counter. A timestamp-based
//          reference model (position arithmetic, step times, stall
//          threshold) predicts every output after every clock edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_encoder_step_counter;

  localparam int PW = 16;
  localparam int DW = 20;
  localparam int S  = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encoder_step_counter_if #(.POS_WIDTH(PW), .PERIOD_WIDTH(DW)) bus ();

  encoder_step_counter #(
    .POS_WIDTH   (PW),
    .PERIOD_WIDTH(DW),
    .STALL_CYCLES(S)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: time of the last step and output predictions.
  int            cyc;
  int            last;
  logic [PW-1:0] m_pos;
  logic          m_dir;
  logic [DW-1:0] m_period;
  logic          m_valid;
  logic          m_newp;
  logic          m_stalled;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; last = -1;
    m_pos = '0; m_dir = 1'b0; m_period = '0;
    m_valid = 1'b0; m_newp = 1'b0; m_stalled = 1'b1;
  endtask

  task automatic model_edge(input logic st, input logic pol, input logic clr,
                            input logic ld, input logic [PW-1:0] val);
    cyc++;
    if (clr)      m_pos = '0;
    else if (ld)  m_pos = val;
    else if (st)  m_pos = pol ? m_pos + PW'(1) : m_pos - PW'(1);
    m_newp = 1'b0;
    if (st) begin
      if (m_stalled || (cyc - last) >= S || pol != m_dir) begin
        // No usable reference (none, too old, or opposite direction).
        m_dir = pol; m_stalled = 1'b0; m_period = '0; m_valid = 1'b0;
      end else begin
        m_period = DW'(cyc - last); m_valid = 1'b1; m_newp = 1'b1;
      end
      last = cyc;
    end else if (!m_stalled && (cyc - last) >= S) begin
      m_stalled = 1'b1; m_period = '0; m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pos"},    32'(bus.o_position),     32'(m_pos));
    chk({tag, ".dir"},    32'(bus.o_direction),    32'(m_dir));
    chk({tag, ".period"}, 32'(bus.o_period),       32'(m_period));
    chk({tag, ".valid"},  32'(bus.o_period_valid), 32'(m_valid));
    chk({tag, ".newp"},   32'(bus.o_new_period),   32'(m_newp));
    chk({tag, ".stall"},  32'(bus.o_stalled),      32'(m_stalled));
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic tick(input string tag, input logic st, input logic pol,
                      input logic clr, input logic ld, input logic [PW-1:0] val);
    bus.i_step = st; bus.i_polarity = pol; bus.i_clear = clr;
    bus.i_load = ld; bus.i_load_value = val;
    @(posedge clk);
    model_edge(st, pol, clr, ld, val);
    #1;
    check_all(tag);
    pulses += int'(bus.o_new_period);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".pos"},    32'(bus.o_position),     32'h0);
    chk({tag, ".dir"},    32'(bus.o_direction),    32'h0);
    chk({tag, ".period"}, 32'(bus.o_period),       32'h0);
    chk({tag, ".valid"},  32'(bus.o_period_valid), 32'h0);
    chk({tag, ".newp"},   32'(bus.o_new_period),   32'h0);
    chk({tag, ".stall"},  32'(bus.o_stalled),      32'h1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lp;
    logic p;
    int   gap;
    int   r;

    bus.i_step = 1'b0; bus.i_polarity = 1'b0; bus.i_clear = 1'b0;
    bus.i_load = 1'b0; bus.i_load_value = '0;
    model_reset();

    // Reset state, then 50 quiet cycles.
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("in_reset");
    rst_n = 1'b1;
    idle("quiet", 50);
    chk("quiet.stalled", 32'(bus.o_stalled), 32'h1);

    // Five forward steps spaced 10 cycles.
    pulses = 0;
    tick("fwd", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("fwd1.stalled", 32'(bus.o_stalled), 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle("fwd_gap", 9);
      tick("fwd", 1'b1, 1'b1, 1'b0, 1'b0, '0);
      chk("fwd.period", 32'(bus.o_period), 32'd10);
      chk("fwd.valid", 32'(bus.o_period_valid), 32'h1);
    end
    chk("fwd.position", 32'(bus.o_position), 32'd5);
    chk("fwd.pulses", 32'(pulses), 32'd4);

    // Wrap, clear, and clear coinciding with a step.
    tick("load", 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF);
    tick("wrap_up", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("wrap_up.position", 32'(bus.o_position), 32'h8000);
    tick("clear", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    tick("wrap_dn", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("wrap_dn.position", 32'(bus.o_position), 32'hFFFF);
    idle("gap", 4);
    tick("clr_step", 1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk("clr_step.position", 32'(bus.o_position), 32'h0);
    chk("clr_step.period", 32'(bus.o_period), 32'd5);

    // Reversal after 8-cycle forward steps.
    tick("rev", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      idle("rev_gap", 7);
      tick("rev", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    end
    chk("rev.fwd_period", 32'(bus.o_period), 32'd8);
    idle("rev_gap", 7);
    tick("rev_back", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rev_back.dir", 32'(bus.o_direction), 32'h0);
    chk("rev_back.valid", 32'(bus.o_period_valid), 32'h0);
    chk("rev_back.period", 32'(bus.o_period), 32'h0);
    chk("rev_back.newp", 32'(bus.o_new_period), 32'h0);
    idle("rev_gap", 11);
    tick("rev_back2", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rev_back2.period", 32'(bus.o_period), 32'd12);
    chk("rev_back2.valid", 32'(bus.o_period_valid), 32'h1);

    // Stall exactly at interval S.
    idle("pre_stall", 3);
    tick("stall_ref", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle("stall_wait", S - 1);
    chk("stall.before", 32'(bus.o_stalled), 32'h0);
    idle("stall_wait", 1);
    chk("stall.at", 32'(bus.o_stalled), 32'h1);
    chk("stall.valid", 32'(bus.o_period_valid), 32'h0);

    // Step at interval S-1 yields a period; step at exactly S does not.
    tick("w99", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    idle("w99_gap", S - 2);
    tick("w99", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("w99.period", 32'(bus.o_period), 32'(S - 1));
    chk("w99.stalled", 32'(bus.o_stalled), 32'h0);
    idle("w100_gap", S - 1);
    tick("w100", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("w100.valid", 32'(bus.o_period_valid), 32'h0);
    chk("w100.stalled", 32'(bus.o_stalled), 32'h0);

    // Three consecutive steps, then asynchronous reset during RUNNING.
    idle("pre_burst", S + 5);
    pulses = 0;
    for (int i = 0; i < 3; i++) tick("burst", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("burst.period", 32'(bus.o_period), 32'd1);
    chk("burst.pulses", 32'(pulses), 32'd2);
    bus.i_step = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle("post_rst", 3);

    // Randomized traffic against the model.
    lp = 1'b1;
    for (int e = 0; e < 300; e++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      gap = int'($urandom_range(1, 12));
      else if (r < 8) gap = int'($urandom_range(S - 5, S + 5));
      else            gap = int'($urandom_range(1, 2));
      for (int k = 1; k < gap; k++)
        tick("rnd_idle", 1'b0, 1'b0, ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 15) == 0), PW'($urandom));
      p  = ($urandom_range(0, 3) != 0) ? lp : ~lp;
      lp = p;
      tick("rnd_step", 1'b1, p, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), PW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoder_step_counter.md
Name: encoder_step_counter

Overview:
- Consumes the single-cycle step/polarity pulses produced by the quadrature encoder decoder stage.
- Maintains a signed motor position count.
- Measures the clock-cycle interval between consecutive same-direction steps, giving a period-based speed estimate.
- Flags stall when no step arrives within a timeout. Sits between the encoder decoder and the motor control / register interface.

Parameters:
- POS_WIDTH, 16, width of the position counter, two's complement.
- PERIOD_WIDTH, 20, width of the interval counter and of o_period.
- STALL_CYCLES, 1000000, step interval in cycles at which motion is declared stalled. Legal range 2..2^PERIOD_WIDTH-1.

Ports:
- i_clk  input  1  master clock
- i_rst_n  input  1  reset
- i_step  input  1  single-cycle step pulse from decoder
- i_polarity  input  1  step direction, qualified by i_step: 1 = forward (+1), 0 = backward (-1)
- i_clear  input  1  synchronous position clear
- i_load  input  1  synchronous position load strobe
- i_load_value  input  POS_WIDTH  value loaded on i_load
- o_position  output  POS_WIDTH  signed position count
- o_direction  output  1  polarity of the most recent step
- o_period  output  PERIOD_WIDTH  cycles between the last two same-direction steps
- o_period_valid  output  1  o_period holds a valid measurement
- o_new_period  output  1  single-cycle pulse when o_period is updated
- o_stalled  output  1  no step within STALL_CYCLES, or no step since reset

Behaviour:
- Reset is asynchronous, active-low, on i_rst_n; clock is i_clk.
- Reset values:
  - o_position = 0, o_direction = 0, o_period = 0, o_period_valid = 0, o_new_period = 0.
  - o_stalled = 1, state = IDLE, interval counter cnt = 0.
- All outputs are registered: one cycle of latency from i_step to the updated outputs.

Position path:
- Priority order is i_clear > i_load > step.
- i_clear: o_position <= 0. i_load: o_position <= i_load_value.
- A step coinciding with i_clear or i_load is dropped from the position only. The speed path still processes it.
- Step: o_position +1 when i_polarity = 1, -1 when i_polarity = 0.
- Modular wrap, no saturation: 0x7FFF +1 -> 0x8000; 0x0000 -1 -> 0xFFFF (for POS_WIDTH = 16).

Interval counter:
- cnt clears to 0 on every step.
- Otherwise cnt increments each cycle, saturating at STALL_CYCLES.
- Measured interval = cnt+1 at the step cycle. Steps on consecutive cycles give a period of 1.

State machine:
- IDLE: no reference step.
  - Step -> ARMED.
  - o_direction <= i_polarity, o_stalled <= 0. No period update.
- ARMED: one reference step seen.
  - Same-direction step with interval < STALL_CYCLES -> RUNNING. o_period <= interval, o_period_valid <= 1, o_new_period pulses.
- RUNNING:
  - Same-direction step with interval < STALL_CYCLES: o_period <= interval, o_new_period pulses, stays in RUNNING.
- Direction change (ARMED or RUNNING):
  - Step with i_polarity != o_direction -> ARMED.
  - o_direction <= i_polarity, o_period_valid <= 0, o_period <= 0, no o_new_period, cnt <= 0.
- Stall (ARMED or RUNNING):
  - Interval reaches STALL_CYCLES with no step -> IDLE.
  - o_stalled <= 1, o_period_valid <= 0, o_period <= 0. o_direction is held.
- Boundaries:
  - A step arriving exactly when the interval equals STALL_CYCLES is handled as the IDLE first-step case: -> ARMED, o_stalled stays 0, no period.
  - i_clear and i_load never affect state, cnt or the period outputs.
  - cnt saturation prevents wrap in IDLE.
  - Reset asserted mid-measurement returns every output to its reset value immediately (asynchronous).
- o_new_period is high for exactly one cycle per update, never for two consecutive cycles unless steps arrive on consecutive cycles.

Test Plan:
- Reset release, no stimulus for 50 cycles -> o_position = 0, o_period = 0, o_period_valid = 0, o_new_period = 0, o_stalled = 1.
- 5 forward steps spaced 10 cycles -> o_position = 5, o_stalled = 0 after step 1, o_period = 10 and o_period_valid = 1 after step 2, exactly 4 o_new_period pulses.
- Wrap check:
  - Load 0x7FFF, then 1 forward step -> o_position = 0x8000.
  - Clear, then 1 backward step -> 0xFFFF.
  - i_clear together with i_step -> o_position = 0, period still measured.
- Forward steps at 8-cycle spacing, then a backward step -> o_direction = 0, o_period_valid = 0, o_period = 0, no pulse. Next backward step 12 cycles later -> o_period = 12, o_period_valid = 1.
- STALL_CYCLES = 100: a step followed by 100 idle cycles -> o_stalled = 1 exactly at interval 100, o_period_valid = 0. A step arriving at interval 99 instead -> o_period = 99, no stall.
- Steps on 3 consecutive cycles -> o_period = 1 with 2 pulses. Reset asserted during RUNNING -> all outputs return to reset values without waiting for a clock edge.
